// File: rtl/operand_stack_pkg.sv
//------------------------------------------------------------------------------
// Module  : operand_stack_pkg
// Brief   : Shared definitions for the CPU operand stack: default geometry,
//           error-flag bit positions and the push/pop operation decode.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package operand_stack_pkg;

  // Default geometry shared with the CPU control
  localparam int DEF_WIDTH   = 8;
  localparam int DEF_DEPTH   = 16;

  // Error-flag vector layout
  localparam int ERR_W       = 2;
  localparam int ERR_OVF_BIT = 0;
  localparam int ERR_UDF_BIT = 1;

  // Operation requested in a cycle, encoded as {push, pop}
  typedef enum logic [1:0] {
    OP_IDLE    = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } stack_op_e;

  function automatic stack_op_e decode_op(input logic push, input logic pop);
    return stack_op_e'({push, pop});
  endfunction

endpackage

`default_nettype wire

// File: rtl/stack_mem.sv
//------------------------------------------------------------------------------
// Module  : stack_mem
// Brief   : Operand-stack storage: register array with one synchronous write
//           port and two combinational read ports (top and second entry).
//           Contents are not reset.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module stack_mem
  import operand_stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr_top,
  input  logic [AW-1:0]    raddr_next,
  output logic [WIDTH-1:0] rdata_top,
  output logic [WIDTH-1:0] rdata_next
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Single write port; storage deliberately has no reset
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata_top  = r_mem[raddr_top];
  assign rdata_next = r_mem[raddr_next];

endmodule

`default_nettype wire

// File: rtl/operand_stack.sv
//------------------------------------------------------------------------------
// Module  : operand_stack
// Brief   : LIFO operand stack with simultaneous push/pop (replace-top),
//           saturating stack pointer and overflow/underflow flags.
//           Macro STACK_ERR_LATCH_EN: when defined the error flags are sticky
//           until clr_err; otherwise they are single-cycle pulses.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module operand_stack
  import operand_stack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         data_in,
  input  logic                     clr_err,
  output logic [WIDTH-1:0]         data_out,
  output logic [WIDTH-1:0]         next_out,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int               AW         = $clog2(DEPTH);
  localparam logic [AW:0]      C_FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]      C_ONE      = (AW+1)'(1);
  localparam logic [AW:0]      C_TWO      = (AW+1)'(2);

  logic [AW:0]       r_sp;
  logic [AW:0]       w_sp_nxt;
  logic [ERR_W-1:0]  r_err;
  logic [ERR_W-1:0]  w_err;
  logic              w_we;
  logic              w_mem_we;
  logic [AW-1:0]     w_waddr;
  logic [AW-1:0]     w_top_addr;
  logic [AW-1:0]     w_next_addr;
  logic [WIDTH-1:0]  w_rd_top;
  logic [WIDTH-1:0]  w_rd_next;
  logic              w_full;
  logic              w_empty;
  stack_op_e         w_op;

  assign w_op        = decode_op(push, pop);
  assign w_full      = (r_sp == C_FULL_CNT);
  assign w_empty     = (r_sp == '0);
  // When sp is 0 or 1 these wrap to a legal index; the outputs are masked
  assign w_top_addr  = AW'(r_sp - C_ONE);
  assign w_next_addr = AW'(r_sp - C_TWO);

  // Next stack pointer, write request and error detection
  always_comb begin
    w_sp_nxt = r_sp;
    w_we     = 1'b0;
    w_waddr  = r_sp[AW-1:0];
    w_err    = '0;
    case (w_op)
      OP_PUSH: begin
        if (!w_full) begin
          w_we     = 1'b1;
          w_sp_nxt = r_sp + C_ONE;
        end else begin
          w_err[ERR_OVF_BIT] = 1'b1;
        end
      end
      OP_POP: begin
        if (!w_empty) begin
          w_sp_nxt = r_sp - C_ONE;
        end else begin
          w_err[ERR_UDF_BIT] = 1'b1;
        end
      end
      OP_REPLACE: begin
        w_we = 1'b1;
        if (!w_empty) begin
          w_waddr = w_top_addr;
        end else begin
          // Nothing to replace: behaves as a push but still flags underflow
          w_sp_nxt           = C_ONE;
          w_err[ERR_UDF_BIT] = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // A push coinciding with an active reset must not land in storage
  assign w_mem_we = w_we & reset;

  // Stack pointer register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sp <= '0;
    end else begin
      r_sp <= w_sp_nxt;
    end
  end

`ifdef STACK_ERR_LATCH_EN
  // Sticky error flags: a new error beats a simultaneous clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= '0;
    end else begin
      r_err <= w_err | (r_err & {ERR_W{~clr_err}});
    end
  end
`else
  logic w_unused_clr_err;
  assign w_unused_clr_err = clr_err;

  // Error flags pulse for one cycle after the offending edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= '0;
    end else begin
      r_err <= w_err;
    end
  end
`endif

  stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_stack_mem (
    .clk        (clk),
    .we         (w_mem_we),
    .waddr      (w_waddr),
    .wdata      (data_in),
    .raddr_top  (w_top_addr),
    .raddr_next (w_next_addr),
    .rdata_top  (w_rd_top),
    .rdata_next (w_rd_next)
  );

  assign data_out  = w_empty       ? '0 : w_rd_top;
  assign next_out  = (r_sp < C_TWO) ? '0 : w_rd_next;
  assign count     = r_sp;
  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = r_err[ERR_OVF_BIT];
  assign underflow = r_err[ERR_UDF_BIT];

endmodule

`default_nettype wire

// File: doc/operand_stack.md
OPERAND_STACK -- requirements
Module: operand_stack

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, the data word width in bits.
REQ-002 SHALL provide parameter DEPTH, default 16, the number of entries; legal values are powers of two from 4 to 256.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL provide port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide port push  input  1  request to write data_in on top of the stack this cycle.
REQ-006 SHALL provide port pop  input  1  request to remove the top entry this cycle.
REQ-007 SHALL provide port data_in  input  WIDTH  value to push.
REQ-008 SHALL provide port clr_err  input  1  clears the error flags.
REQ-009 SHALL provide port data_out  output  WIDTH  top-of-stack value; 0 when empty.
REQ-010 SHALL provide port next_out  output  WIDTH  second entry; 0 when count < 2.
REQ-011 SHALL provide port count  output  log2(DEPTH)+1  number of valid entries.
REQ-012 SHALL provide port full  output  1  high when count == DEPTH.
REQ-013 SHALL provide port empty  output  1  high when count == 0.
REQ-014 SHALL provide port overflow  output  1  push was rejected because the stack was full.
REQ-015 SHALL provide port underflow  output  1  pop was rejected because the stack was empty.

Function
REQ-016 SHALL use a stack pointer sp, 0..DEPTH; count equals sp; storage is mem[0..DEPTH-1]; top is mem[sp-1].
REQ-017 SHALL, on push only with count < DEPTH, write mem[sp] <= data_in and set sp <= sp+1.
REQ-018 SHALL, on push only when full, leave mem and sp unchanged and raise overflow.
REQ-019 SHALL, on pop only with count > 0, set sp <= sp-1 without clearing storage.
REQ-020 SHALL, on pop only when empty, leave sp at 0 and raise underflow.
REQ-021 SHALL, on push and pop together with count > 0 (including full), replace the top: mem[sp-1] <= data_in with sp unchanged; no flag is raised.
REQ-022 SHALL, on push and pop together when empty, perform the push (sp becomes 1) and raise underflow.
REQ-023 SHALL derive data_out, next_out, full, empty and count combinationally from registered sp and mem, so each reflects an operation in the cycle after its edge (1-cycle latency).
REQ-024 SHALL never index outside the array: sp saturates at 0 and DEPTH, and there is no wrap-around.
REQ-025 SHALL hold all state when push and pop are both low.

Reset
REQ-026 SHALL, while reset is low, force sp=0, overflow=0 and underflow=0 asynchronously, so that data_out=0, next_out=0, count=0, empty=1 and full=0.
REQ-027 SHALL NOT reset mem contents; reset in the middle of a push discards that push.
REQ-028 SHALL ignore push, pop and clr_err during the first edge after reset is released only if reset is still low at that edge.

Configuration
REQ-029 SHALL, with STACK_ERR_LATCH_EN defined, make overflow and underflow sticky: each sets on its error and clears only on clr_err or reset; an error in the same cycle as clr_err wins and the flag stays set.
REQ-030 SHALL, without STACK_ERR_LATCH_EN, make overflow and underflow registered single-cycle pulses high in the cycle after the error; clr_err is ignored.

Structure
REQ-031 SHALL take the defaults for WIDTH and DEPTH, and the error-flag bit positions, from the shared definitions file used by the CPU control.
REQ-032 SHALL place storage in one sub-module, stack_mem: a register array with one synchronous write port and two combinational read ports (top and second). The pointer and flag logic stay in operand_stack.

Verification
REQ-033 Reset then push 0x11, 0x22, 0x33 -> data_out=0x33, next_out=0x22, count=3, empty=0.
REQ-034 Push 16 values 0x00..0x0F, then one more push of 0xAA -> full=1, count=16, data_out=0x0F, overflow=1.
REQ-035 Pop from an empty stack -> underflow=1, count=0, data_out=0; with the macro, the flag holds until clr_err, and without it, the flag is a 1-cycle pulse.
REQ-036 Stack holds 0x05, 0x07; assert push and pop together with data_in=0x0C -> data_out=0x0C, next_out=0x05, count=2, no flag.
REQ-037 Empty stack; assert push and pop together with data_in=0x44 -> count=1, data_out=0x44, underflow=1.
REQ-038 Stack with count=5; assert reset low between clock edges -> count=0 and empty=1 immediately, before the next edge.
